// File: rtl/alu_retire_stage_if.sv
// Beat interface between the ALU, the retire stage and the register file:
// the upstream instruction beat plus the writeback beat, both valid/ready.
interface alu_retire_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_result;
    logic [2:0]      in_status;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic            in_branch;
    logic [2:0]      in_funct3;
    logic            in_we;
    logic [4:0]      in_rd;

    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    // Environment side: drives instruction beats, consumes writebacks.
    modport master (
        output in_valid, in_result, in_status, in_pc, in_imm,
               in_branch, in_funct3, in_we, in_rd, wb_ready,
        input  in_ready, wb_valid, wb_rd, wb_data
    );

    // Retire stage side.
    modport slave (
        input  in_valid, in_result, in_status, in_pc, in_imm,
               in_branch, in_funct3, in_we, in_rd, wb_ready,
        output in_ready, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/alu_retire_stage.sv
// Execute/writeback stage behind the ALU: resolves conditional branches into
// a registered redirect, buffers register writebacks in a 2-entry queue and
// counts retired instructions.
module alu_retire_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_retire_stage_if.slave bus,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              branch_err,
    output logic [31:0]       retire_count
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e            occ_q, occ_d;
    logic [4:0]      head_rd_q, head_rd_d, tail_rd_q, tail_rd_d;
    logic [XLEN-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            branch_err_q, branch_err_d;
    logic [31:0]     retire_count_q, retire_count_d;

    logic in_ready;
    logic wb_valid;
    logic live;
    logic push;
    logic pop;
    logic taken;
    logic cond_ok;
    logic flag_n, flag_v, flag_z;

    // in_ready depends on registered occupancy only, never on wb_ready.
    assign in_ready     = (32'(occ_q) != DEPTH);
    assign wb_valid     = (occ_q != OCC_EMPTY);
    assign bus.in_ready = in_ready;
    assign bus.wb_valid = wb_valid;
    assign bus.wb_rd    = head_rd_q;
    assign bus.wb_data  = head_data_q;

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign branch_err     = branch_err_q;
    assign retire_count   = retire_count_q;

    // Acceptance, squash, branch resolution and queue next-state.
    always_comb begin
        // A beat accepted while a redirect is visible is wrong-path and dropped.
        live = bus.in_valid && in_ready && !redirect_valid_q;
        push = live && bus.in_we && (bus.in_rd != 5'd0);
        pop  = wb_valid && bus.wb_ready;

        {flag_n, flag_v, flag_z} = bus.in_status;
        cond_ok = 1'b1;
        taken   = 1'b0;
        case (bus.in_funct3)
            3'b000:  taken = flag_z;
            3'b001:  taken = !flag_z;
            3'b100:  taken = flag_n ^ flag_v;
            3'b101:  taken = !(flag_n ^ flag_v);
            default: cond_ok = 1'b0;
        endcase

        redirect_valid_d = live && bus.in_branch && taken;
        redirect_pc_d    = redirect_valid_d ? (bus.in_pc + bus.in_imm) : redirect_pc_q;
        branch_err_d     = live && bus.in_branch && !cond_ok;
        retire_count_d   = live ? (retire_count_q + 32'd1) : retire_count_q;

        occ_d       = occ_q;
        head_rd_d   = head_rd_q;
        head_data_d = head_data_q;
        tail_rd_d   = tail_rd_q;
        tail_data_d = tail_data_q;
        // The head is the registered output, so a push at occupancy 1 with a
        // concurrent pop writes straight into the head slot.
        case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_rd_d   = bus.in_rd;
                    head_data_d = bus.in_result;
                    occ_d       = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    head_rd_d   = bus.in_rd;
                    head_data_d = bus.in_result;
                end else if (push) begin
                    tail_rd_d   = bus.in_rd;
                    tail_data_d = bus.in_result;
                    occ_d       = OCC_FULL;
                end else if (pop) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    head_rd_d   = tail_rd_q;
                    head_data_d = tail_data_q;
                    occ_d       = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    // All stage state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q            <= OCC_EMPTY;
            head_rd_q        <= '0;
            head_data_q      <= '0;
            tail_rd_q        <= '0;
            tail_data_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            branch_err_q     <= 1'b0;
            retire_count_q   <= '0;
        end else begin
            occ_q            <= occ_d;
            head_rd_q        <= head_rd_d;
            head_data_q      <= head_data_d;
            tail_rd_q        <= tail_rd_d;
            tail_data_q      <= tail_data_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            branch_err_q     <= branch_err_d;
            retire_count_q   <= retire_count_d;
        end
    end

endmodule

// File: tb/tb_alu_retire_stage.sv
// Bench for alu_retire_stage: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_alu_retire_stage;
    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            branch_err;
    logic [31:0]     retire_count;

    alu_retire_stage_if #(.XLEN(XLEN)) bus ();

    alu_retire_stage #(.XLEN(XLEN), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .branch_err     (branch_err),
        .retire_count   (retire_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [36:0] mq[$];
    bit          m_rv;
    bit          m_err;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit [31:0] res, input bit [2:0] st,
                         input bit [31:0] pc, input bit [31:0] imm, input bit br,
                         input bit [2:0] f3, input bit we, input bit [4:0] rd);
        bus.in_valid  = v;
        bus.in_result = res;
        bus.in_status = st;
        bus.in_pc     = pc;
        bus.in_imm    = imm;
        bus.in_branch = br;
        bus.in_funct3 = f3;
        bus.in_we     = we;
        bus.in_rd     = rd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        mq.delete();
        m_rv  = 0;
        m_err = 0;
        m_pc  = 0;
        m_cnt = 0;
    endtask

    task automatic check_all();
        chk("in_ready", 64'(bus.in_ready), 64'(mq.size() != 2));
        chk("wb_valid", 64'(bus.wb_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) chk("wb_head", {27'd0, bus.wb_rd, bus.wb_data}, 64'(mq[0]));
        chk("redirect_valid", 64'(redirect_valid), 64'(m_rv));
        chk("redirect_pc", 64'(redirect_pc), 64'(m_pc));
        chk("branch_err", 64'(branch_err), 64'(m_err));
        chk("retire_count", 64'(retire_count), 64'(m_cnt));
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
        chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
        chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        chk("rst_branch_err", 64'(branch_err), 64'd0);
        chk("rst_retire_count", 64'(retire_count), 64'd0);
    endtask

    // One clock: model decides from pre-edge state and inputs, then compares.
    task automatic step();
        bit ok, pop, tk, bad, lt, eq;
        logic [36:0] beat;
        ok   = bus.in_valid && (mq.size() != 2) && !m_rv;
        pop  = (mq.size() != 0) && bus.wb_ready;
        beat = {bus.in_rd, bus.in_result};
        eq   = bus.in_status[0];
        lt   = bus.in_status[2] != bus.in_status[1];
        tk   = 0;
        bad  = 0;
        if (bus.in_funct3 == 3'b000)      tk = eq;
        else if (bus.in_funct3 == 3'b001) tk = !eq;
        else if (bus.in_funct3 == 3'b100) tk = lt;
        else if (bus.in_funct3 == 3'b101) tk = !lt;
        else                               bad = 1;
        tk  = tk && ok && bus.in_branch;
        bad = bad && ok && bus.in_branch;
        if (tk) m_pc = bus.in_pc + bus.in_imm;
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (ok && bus.in_we && bus.in_rd != 5'd0) mq.push_back(beat);
        if (ok) m_cnt = m_cnt + 32'd1;
        m_rv  = tk;
        m_err = bad;
        check_all();
    endtask

    initial begin
        logic [31:0] base;
        bit [2:0] f3_pool [8];
        f3_pool = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};

        // Reset state.
        idle();
        bus.wb_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back writes.
        bus.wb_ready = 1'b1;
        drive(1, 32'h5, 0, 0, 0, 0, 0, 1, 5'd3); step();
        drive(1, 32'h7, 0, 0, 0, 0, 0, 1, 5'd4); step();
        idle(); step();
        chk("b2b_count", 64'(retire_count), 64'd2);

        // Backpressure: third beat stalls until the queue drains.
        bus.wb_ready = 1'b0;
        drive(1, 32'hA, 0, 0, 0, 0, 0, 1, 5'd5); step();
        drive(1, 32'hB, 0, 0, 0, 0, 0, 1, 5'd6); step();
        drive(1, 32'hC, 0, 0, 0, 0, 0, 1, 5'd7); step();
        step();
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        bus.wb_ready = 1'b1;
        step();
        step();
        idle(); step(); step();
        chk("bp_count", 64'(retire_count), 64'd5);

        // Taken BEQ then a wrong-path beat in the following cycle.
        base = m_cnt;
        drive(1, 0, 3'b001, 32'h100, 32'hFFFF_FFF0, 1, 3'b000, 0, 0); step();
        chk("beq_target", 64'(redirect_pc), 64'h0000_00F0);
        drive(1, 32'h99, 0, 0, 0, 0, 0, 1, 5'd9); step();
        chk("squash_count", 64'(retire_count), 64'(base + 32'd1));
        idle(); step();

        // BLT / BGE with N=1 V=1 Z=0, then unsupported funct3.
        drive(1, 0, 3'b110, 32'h200, 32'h8, 1, 3'b100, 0, 0); step();
        drive(1, 0, 3'b110, 32'h200, 32'h8, 1, 3'b101, 0, 0); step();
        chk("bge_target", 64'(redirect_pc), 64'h208);
        idle(); step();
        drive(1, 0, 3'b000, 32'h300, 32'h4, 1, 3'b010, 0, 0); step();
        idle(); step();

        // Write to x0 is counted but not queued.
        drive(1, 32'h1234, 0, 0, 0, 0, 0, 1, 5'd0); step();
        idle(); step();

        // Counter wrap.
        force dut.retire_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count_q;
        m_cnt = 32'hFFFF_FFFF;
        chk("wrap_preload", 64'(retire_count), 64'hFFFF_FFFF);
        drive(1, 32'h1, 0, 0, 0, 0, 0, 0, 5'd1); step();
        chk("wrap_zero", 64'(retire_count), 64'd0);
        idle(); step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
                  $urandom, $urandom, $urandom_range(0, 3) == 0,
                  f3_pool[$urandom_range(0, 7)], $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 31)));
            bus.wb_ready = $urandom_range(0, 3) != 0;
            step();
        end

        // Reset with two queued entries and a redirect pending.
        idle();
        bus.wb_ready = 1'b1;
        repeat (3) step();
        bus.wb_ready = 1'b0;
        drive(1, 32'hAA, 0, 0, 0, 0, 0, 1, 5'd10); step();
        drive(1, 32'hBB, 3'b001, 32'h400, 32'h10, 1, 3'b000, 1, 5'd11); step();
        chk("pre_rst_full", 64'(bus.in_ready), 64'd0);
        chk("pre_rst_redirect", 64'(redirect_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values();
        idle();
        bus.wb_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_retire_stage.md
# alu_retire_stage

Execute/writeback stage that sits directly downstream of `alu`. Captures each ALU result with its `{N,V,Z}` status and instruction context. Resolves conditional branches into a registered PC redirect. Buffers register-file writebacks in a 2-entry queue with a valid/ready handshake. Also keeps a free-running retired-instruction counter.

## Interface
Parameters:
- `XLEN`, 32, datapath width (ALU result, PC, immediate)
- `DEPTH`, 2, writeback queue entries (fixed at 2; other values unsupported)

Ports:
- `clk` in 1: single clock; all state updates on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `in_valid` in 1: upstream beat valid
- `in_ready` out 1: stage can accept a beat
- `in_result` in XLEN: ALU `out`
- `in_status` in 3: ALU `status` = {N, V, Z}
- `in_pc` in XLEN: PC of the instruction
- `in_imm` in XLEN: sign-extended branch offset
- `in_branch` in 1: instruction is a conditional branch
- `in_funct3` in 3: branch condition; 000 BEQ, 001 BNE, 100 BLT, 101 BGE
- `in_we` in 1: instruction writes `in_rd`
- `in_rd` in 5: destination register
- `wb_valid` out 1: writeback beat valid
- `wb_ready` in 1: register file accepts the beat
- `wb_rd` out 5: writeback register
- `wb_data` out XLEN: writeback data
- `redirect_valid` out 1: one-cycle taken-branch pulse
- `redirect_pc` out XLEN: branch target
- `branch_err` out 1: one-cycle pulse for an unsupported `in_funct3` on a branch
- `retire_count` out 32: count of retired instructions

## Operation
- Accept condition: `in_valid && in_ready`. `in_ready = (occupancy != 2)`, driven combinationally from registered occupancy only.
- Squash: a beat accepted in a cycle where `redirect_valid == 1` is wrong-path. It is discarded entirely: no enqueue, no redirect, no count.
- Enqueue: an accepted, non-squashed beat with `in_we && in_rd != 0` is pushed as {`in_rd`, `in_result`}. Beats with `in_we == 0` or `in_rd == 0` are not enqueued.
- Branch resolution, for an accepted, non-squashed beat with `in_branch == 1`:
  - BEQ taken iff Z.
  - BNE taken iff !Z.
  - BLT taken iff N^V.
  - BGE taken iff !(N^V).
  - Any other `in_funct3` is not taken and pulses `branch_err` next cycle.
- Taken branch: next cycle `redirect_valid = 1` and `redirect_pc = in_pc + in_imm`, modulo 2^XLEN (wrap, no overflow flag).
- `redirect_pc` holds its last value until the next taken branch.
- Queue: FIFO order, 2 entries. `wb_valid = (occupancy != 0)`. `wb_rd`/`wb_data` come from the head entry, are registered, and stay stable while `wb_valid && !wb_ready`.
- Pop on `wb_valid && wb_ready`.
- Simultaneous push and pop at occupancy 1: occupancy stays 1, the old head leaves, and the new entry becomes head next cycle.
- At occupancy 2 no push is possible (`in_ready` low).
- `retire_count` increments by 1 per accepted, non-squashed beat, whether or not it writes back. It wraps from 0xFFFFFFFF to 0.
- Reset (`rst_n` low, any time, including mid-transfer):
  - Occupancy 0; queued entries are lost.
  - `wb_valid` 0, `wb_rd` 0, `wb_data` 0.
  - `redirect_valid` 0, `redirect_pc` 0, `branch_err` 0.
  - `retire_count` 0.
  - `in_ready` 1.

## Timing
- Latency from acceptance to `wb_valid` is 1 cycle when the queue is empty.
- Latency from acceptance to `redirect_valid` / `branch_err` is exactly 1 cycle.
- Both pulses last exactly 1 cycle.
- Throughput is 1 beat/cycle while `wb_ready` stays high.
- At most one wrong-path beat is squashed per taken branch: the beat accepted in the cycle `redirect_valid` is high. Upstream must have redirected by the following cycle.
- `in_ready` has no combinational path from `wb_ready`. The slot freed by a pop becomes visible one cycle later.
- Reset is asserted asynchronously; release is synchronous to `clk`.

## Test plan
- Back-to-back writes: ADD results 0x5, 0x7 to x3, x4 with `wb_ready` = 1.
  - Required: `wb` beats (3,0x5) then (4,0x7) in consecutive cycles, one cycle after each acceptance.
  - Required: `retire_count` = 2.
- Backpressure: hold `wb_ready` = 0 and offer 3 beats.
  - Required: `in_ready` falls after 2 acceptances and the third beat stalls.
  - Release `wb_ready`. Required: all 3 drain in order with no loss or duplication.
- Taken BEQ: status 3'b001, pc 0x100, imm 0xFFFFFFF0, with the next beat presented in the following cycle.
  - Required: `redirect_valid` pulse, `redirect_pc` = 0x000000F0.
  - Required: the following beat is squashed and `retire_count` increments by 1 only.
- BLT/BGE: status {N=1,V=1,Z=0}.
  - Required: BLT not taken, BGE taken.
  - `funct3` 010: no redirect, `branch_err` pulses once.
- x0 and wrap:
  - Write to rd = 0. Required: no `wb_valid`, but `retire_count` increments.
  - Preload `retire_count` to 0xFFFFFFFF via 2^32−1 beats, or force in a fast sim. Required: the next beat wraps it to 0.
- Reset mid-operation: assert `rst_n` low with 2 queued entries and a redirect pending.
  - Required: all outputs take their reset values immediately, with no `wb` beat after release.
